// File: rtl/key_pio_pkg.sv
// Register map and FSM state encoding shared by the key PIO servicer and anything else
// that talks to the edge-capture key PIO.
package key_pio_pkg;

    localparam logic [1:0] KEY_DATA = 2'd0;
    localparam logic [1:0] KEY_MASK = 2'd2;
    localparam logic [1:0] KEY_EDGE = 2'd3;

    typedef enum logic [2:0] {
        S_MASK,
        S_IDLE,
        S_CAP_A,
        S_CAP_W,
        S_CLR,
        S_LVL_A,
        S_LVL_W,
        S_EMIT
    } key_state_t;

endpackage

// File: rtl/key_irq_servicer.sv
// Autonomous Avalon-MM master for the edge-capture key PIO: programs the irq mask, then on irq
// reads/clears edge_capture and samples the level, emitting {edges, level} on a valid/ready stream.
module key_irq_servicer
    import key_pio_pkg::*;
#(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] INIT_MASK = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic [31:0]      avm_readdata,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_mask_load,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic             busy
);

    key_state_t       state, state_nxt;
    logic [WIDTH-1:0] mask_reg;
    logic             mask_pend;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] rd_bits;
    logic             unused_rdata;

    assign rd_bits      = avm_readdata[WIDTH-1:0];
    assign unused_rdata = ^avm_readdata[31:WIDTH];

    assign evt_edges = cap;
    assign evt_level = lvl;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_MASK;
            mask_reg  <= INIT_MASK;
            mask_pend <= 1'b0;
            cap       <= '0;
            lvl       <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAP_W) cap <= rd_bits;
            if (state == S_LVL_W) lvl <= rd_bits;
            // A load landing in the S_MASK cycle must survive so the newer mask gets written too.
            if (cfg_mask_load) begin
                mask_reg  <= cfg_mask;
                mask_pend <= 1'b1;
            end else if (state == S_MASK) begin
                mask_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = KEY_DATA;
        avm_writedata  = '0;
        evt_valid      = 1'b0;
        case (state)
            S_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = KEY_MASK;
                avm_writedata  = {{(32-WIDTH){1'b0}}, mask_reg};
                state_nxt      = S_IDLE;
            end
            S_IDLE: begin
                if (mask_pend)  state_nxt = S_MASK;
                else if (irq)   state_nxt = S_CAP_A;
            end
            S_CAP_A: begin
                avm_chipselect = 1'b1;
                avm_address    = KEY_EDGE;
                state_nxt      = S_CAP_W;
            end
            S_CAP_W: begin
                avm_chipselect = 1'b1;
                avm_address    = KEY_EDGE;
                // Empty capture: irq dropped or got masked between request and read.
                state_nxt      = (rd_bits == '0) ? S_IDLE : S_CLR;
            end
            S_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = KEY_EDGE;
                avm_writedata  = {{(32-WIDTH){1'b0}}, cap};
                state_nxt      = S_LVL_A;
            end
            S_LVL_A: begin
                avm_chipselect = 1'b1;
                avm_address    = KEY_DATA;
                state_nxt      = S_LVL_W;
            end
            S_LVL_W: begin
                avm_chipselect = 1'b1;
                avm_address    = KEY_DATA;
                state_nxt      = S_EMIT;
            end
            S_EMIT: begin
                evt_valid = 1'b1;
                if (evt_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_MASK;
        endcase
        // Reset abandons any access immediately, including the cycle it is asserted in.
        if (reset) begin
            avm_chipselect = 1'b0;
            avm_write_n    = 1'b1;
            avm_address    = KEY_DATA;
            avm_writedata  = '0;
            evt_valid      = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_irq_servicer.sv
// Bench for key_irq_servicer: behavioural falling-edge-capture PIO slave plus directed and
// randomized key scenarios checked against expected {edges, level} events.
module tb_key_irq_servicer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq;
    logic [31:0] avm_readdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [1:0]  cfg_mask = 2'b00;
    logic        cfg_mask_load = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_edges;
    logic [1:0]  evt_level;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_irq_servicer #(.WIDTH(2), .INIT_MASK(2'b11)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .avm_readdata   (avm_readdata),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .cfg_mask       (cfg_mask),
        .cfg_mask_load  (cfg_mask_load),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
        .busy           (busy)
    );

    // Edge-capture PIO slave: falling edges latch, write-1-to-clear, registered readdata.
    logic       slave_rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] key_prev = 2'b11;
    logic [1:0] edge_cap;
    logic [1:0] pio_mask;
    logic [1:0] falls;
    logic [1:0] clr_bits;
    logic       bus_wr;
    int         clr_wr_count = 0;

    assign bus_wr   = avm_chipselect && !avm_write_n;
    assign falls    = key_prev & ~key;
    assign clr_bits = (bus_wr && avm_address == 2'd3) ? avm_writedata[1:0] : 2'b00;
    assign irq      = |(edge_cap & pio_mask);

    always @(posedge clk) begin
        key_prev <= key;
        if (bus_wr && avm_address == 2'd3) clr_wr_count <= clr_wr_count + 1;
        if (slave_rst) begin
            edge_cap     <= 2'b00;
            pio_mask     <= 2'b00;
            avm_readdata <= 32'd0;
        end else begin
            edge_cap <= (edge_cap & ~clr_bits) | falls;
            if (bus_wr && avm_address == 2'd2) pio_mask <= avm_writedata[1:0];
            if (avm_chipselect) begin
                case (avm_address)
                    2'd0:    avm_readdata <= {30'h15555555, key};
                    2'd2:    avm_readdata <= {30'h15555555, pio_mask};
                    2'd3:    avm_readdata <= {30'h15555555, edge_cap};
                    default: avm_readdata <= 32'd0;
                endcase
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (evt_valid) ok = 1'b1;
        end
    endtask

    // Returns once a negedge shows a read cycle at the given address (first cycle of that read).
    task automatic find_read(input logic [1:0] addr, output bit found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n && avm_address == addr) found = 1'b1;
        end
    endtask

    task automatic find_write(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        int n; bit ok;
        reset = 1'b1; slave_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 2'd0 ||
            avm_writedata !== 32'd0 || evt_valid !== 1'b0 || evt_edges !== 2'b00 || evt_level !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: cs=%b wn=%b addr=%0d wd=%h vld=%b edges=%b level=%b, required 0 1 0 0 0 00 00",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, evt_valid, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        reset = 1'b0; slave_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd2 || avm_writedata !== 32'd3) begin
            failures++;
            $display("FAIL reset_mask_write: cs=%b wn=%b addr=%0d wd=%h, required 1 0 2 00000003",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || avm_chipselect !== 1'b0 || pio_mask !== 2'b11) begin
            failures++;
            $display("FAIL reset_idle: busy=%b cs=%b slave_mask=%b, required 0 0 11", busy, avm_chipselect, pio_mask);
        end
        wait_valid(10, n, ok);
        checks++;
        if (ok) begin
            failures++;
            $display("FAIL reset_no_event: evt_valid=1 after %0d cycles, required none", n);
        end
    endtask

    task automatic test_single_edge;
        int n; bit ok;
        @(posedge clk); #1;
        key = 2'b10;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || n != 8) begin
            failures++;
            $display("FAIL single_latency: valid=%b after %0d negedges, required valid after 8", ok, n);
        end
        checks++;
        if (evt_edges !== 2'b01 || evt_level !== 2'b10) begin
            failures++;
            $display("FAIL single_event: edges=%b level=%b, required 01 10", evt_edges, evt_level);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (edge_cap !== 2'b00 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_cleared: slave edge_capture=%b valid=%b, required 00 0", edge_cap, evt_valid);
        end
        key = 2'b11;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_race;
        int n; bit ok, found;
        @(posedge clk); #1;
        key = 2'b10;
        find_read(2'd3, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL race_cap_read: no addr 3 read seen, required one");
        end
        @(posedge clk); #1;
        key = 2'b00;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b01 || evt_level !== 2'b00) begin
            failures++;
            $display("FAIL race_first: valid=%b edges=%b level=%b, required 1 01 00", ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        wait_valid(30, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b10 || evt_level !== 2'b00) begin
            failures++;
            $display("FAIL race_second: valid=%b edges=%b level=%b, required 1 10 00", ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        key = 2'b11;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_backpressure;
        int n; bit ok, stable;
        evt_ready = 1'b0;
        @(posedge clk); #1;
        key = 2'b10;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b01 || evt_level !== 2'b10) begin
            failures++;
            $display("FAIL bp_first: valid=%b edges=%b level=%b, required 1 01 10", ok, evt_edges, evt_level);
        end
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (i == 10) key = 2'b00;
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_edges !== 2'b01 || evt_level !== 2'b10) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_hold: valid=%b edges=%b level=%b at end of hold, required held 1 01 10",
                     evt_valid, evt_edges, evt_level);
        end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        wait_valid(30, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b10 || evt_level !== 2'b00) begin
            failures++;
            $display("FAIL bp_second: valid=%b edges=%b level=%b, required 1 10 00", ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        key = 2'b11;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_mask_load;
        int n; bit ok, found;
        @(posedge clk); #1;
        key = 2'b10;
        find_read(2'd0, found);
        cfg_mask = 2'b10;
        cfg_mask_load = 1'b1;
        @(posedge clk); #1;
        cfg_mask_load = 1'b0;
        wait_valid(20, n, ok);
        checks++;
        if (!found || !ok || evt_edges !== 2'b01 || evt_level !== 2'b10) begin
            failures++;
            $display("FAIL mask_event: lvl_read=%b valid=%b edges=%b level=%b, required 1 1 01 10",
                     found, ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        find_write(found);
        checks++;
        if (!found || avm_address !== 2'd2 || avm_writedata !== 32'd2) begin
            failures++;
            $display("FAIL mask_write: seen=%b addr=%0d wd=%h, required 1 2 00000002", found, avm_address, avm_writedata);
        end
        @(posedge clk); #1;
        key = 2'b11;
        repeat (3) @(posedge clk);
        #1 key = 2'b10;
        wait_valid(30, n, ok);
        checks++;
        if (ok || irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_blocked: valid=%b irq=%b, required 0 0", ok, irq);
        end
        @(posedge clk); #1;
        key = 2'b11;
        cfg_mask = 2'b11;
        cfg_mask_load = 1'b1;
        @(posedge clk); #1;
        cfg_mask_load = 1'b0;
        wait_valid(30, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b01 || evt_level !== 2'b11) begin
            failures++;
            $display("FAIL mask_restore: valid=%b edges=%b level=%b, required 1 01 11", ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_in_clr;
        int n, clr_before; bit ok, found, vld_seen;
        @(posedge clk); #1;
        key = 2'b10;
        find_read(2'd3, found);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        clr_before = clr_wr_count;
        vld_seen = 1'b0;
        @(negedge clk);
        if (evt_valid) vld_seen = 1'b1;
        checks++;
        if (!found || avm_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL clr_reset_bus: cap_read=%b cs=%b during reset, required 1 0", found, avm_chipselect);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        find_write(found);
        if (evt_valid) vld_seen = 1'b1;
        checks++;
        if (!found || avm_address !== 2'd2 || avm_writedata !== 32'd3 || clr_wr_count != clr_before || vld_seen) begin
            failures++;
            $display("FAIL clr_reset_next: seen=%b addr=%0d wd=%h clr_writes=%0d vld=%b, required 1 2 00000003 %0d 0",
                     found, avm_address, avm_writedata, clr_wr_count, vld_seen, clr_before);
        end
        @(posedge clk); #1;
        wait_valid(30, n, ok);
        checks++;
        if (!ok || evt_edges !== 2'b01 || evt_level !== 2'b10) begin
            failures++;
            $display("FAIL clr_reset_leftover: valid=%b edges=%b level=%b, required 1 01 10", ok, evt_edges, evt_level);
        end
        @(posedge clk); #1;
        key = 2'b11;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_random;
        int n, delay; bit ok, stable;
        logic [1:0] sub;
        for (int it = 0; it < 20; it++) begin
            sub   = 2'($urandom_range(1, 3));
            delay = int'($urandom_range(0, 3));
            evt_ready = (delay == 0);
            @(posedge clk); #1;
            key = 2'b11 & ~sub;
            wait_valid(20, n, ok);
            checks++;
            if (!ok || n != 8 || evt_edges !== sub || evt_level !== ~sub) begin
                failures++;
                $display("FAIL random_event[%0d]: valid=%b cycles=%0d edges=%b level=%b, required 1 8 %b %b",
                         it, ok, n, evt_edges, evt_level, sub, ~sub);
            end
            stable = 1'b1;
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                if (evt_valid !== 1'b1 || evt_edges !== sub) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                failures++;
                $display("FAIL random_hold[%0d]: valid=%b edges=%b, required held 1 %b", it, evt_valid, evt_edges, sub);
            end
            evt_ready = 1'b1;
            @(posedge clk); #1;
            key = 2'b11;
            repeat (2 + $urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_race();
        test_backpressure();
        test_mask_load();
        test_reset_in_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
